// File: rtl/multiplicador_signed_if.sv
// Operand/product bundle for the signed multiplier; master drives operands, slave returns the product.
interface multiplicador_signed_if #(
   parameter int N = 25
);
   logic           en;
   logic [N-1:0]   Multiplicandos;
   logic [N-1:0]   Constantes;
   logic [2*N-1:0] Multip;
   logic           valid_out;

   modport master (
      output en, Multiplicandos, Constantes,
      input  Multip, valid_out
   );

   modport slave (
      input  en, Multiplicandos, Constantes,
      output Multip, valid_out
   );
endinterface

// File: rtl/multiplicador_signed.sv
// Registered full-precision signed multiplier, Multip = A*B in 2N bits; latency 1, or 2 with
// MULTIPLICADOR_PIPE_EN (extra input register stage); no backpressure, one product per cycle.
module multiplicador_signed #(
   parameter int N = 25
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multiplicador_signed_if.slave bus
);
   logic [2*N-1:0] multip_q, multip_d;
   logic           valid_q, valid_d;

   logic [N-1:0]   mul_a, mul_b;
   logic           mul_en;
   logic [2*N-1:0] a_ext, b_ext, prod;

`ifdef MULTIPLICADOR_PIPE_EN
   logic [N-1:0] a_q, a_d, b_q, b_d;
   logic         en_q, en_d;

   // Operands are only reloaded on a valid strobe so idle cycles don't toggle the multiplier.
   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      en_d = bus.en;
      if (bus.en) begin
         a_d = bus.Multiplicandos;
         b_d = bus.Constantes;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         en_q <= 1'b0;
      end else begin
         a_q  <= a_d;
         b_q  <= b_d;
         en_q <= en_d;
      end
   end

   assign mul_a  = a_q;
   assign mul_b  = b_q;
   assign mul_en = en_q;
`else
   assign mul_a  = bus.Multiplicandos;
   assign mul_b  = bus.Constantes;
   assign mul_en = bus.en;
`endif

   // Sign-extend to the full product width; (-2^(N-1))^2 still fits in 2N signed bits.
   always_comb begin
      a_ext = {{N{mul_a[N-1]}}, mul_a};
      b_ext = {{N{mul_b[N-1]}}, mul_b};
      prod  = a_ext * b_ext;
   end

   always_comb begin
      multip_d = multip_q;
      valid_d  = mul_en;
      if (mul_en) begin
         multip_d = prod;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         multip_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         multip_q <= multip_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.Multip    = multip_q;
   assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_multiplicador_signed.sv
// Directed and random checks of multiplicador_signed against a per-cycle history model.
module tb_multiplicador_signed;
   localparam int N = 25;
`ifdef MULTIPLICADOR_PIPE_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   multiplicador_signed_if #(.N(N)) bus ();

   multiplicador_signed #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: history of applied (en, product); output at a cycle reflects the entry L back.
   bit             en_h[$];
   logic [2*N-1:0] p_h[$];
   logic [2*N-1:0] exp_m;
   logic           exp_v;

   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      longint sa, sb, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa * sb;
      return p[2*N-1:0];
   endfunction

   task automatic check_m(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_v(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic e, input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
      int idx;
      bus.en             = e;
      bus.Multiplicandos = a;
      bus.Constantes     = b;
      en_h.push_back(e);
      p_h.push_back(ref_mul(a, b));
      @(posedge clk);
      #1;
      idx   = en_h.size() - L;
      exp_v = 1'b0;
      if (idx >= 0) begin
         exp_v = en_h[idx];
         if (en_h[idx]) exp_m = p_h[idx];
      end
      check_m({tag, "_multip"}, bus.Multip, exp_m);
      check_v({tag, "_valid"}, bus.valid_out, exp_v);
   endtask

   task automatic do_reset(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
      rst_n              = 1'b0;
      bus.en             = 1'b1;
      bus.Multiplicandos = a;
      bus.Constantes     = b;
      @(posedge clk);
      #1;
      en_h.delete();
      p_h.delete();
      exp_m = '0;
      check_m({tag, "_multip"}, bus.Multip, '0);
      check_v({tag, "_valid"}, bus.valid_out, 1'b0);
      rst_n = 1'b1;
   endtask

   // Product against a literal from the datasheet, waiting out the latency with idle cycles.
   task automatic directed(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [2*N-1:0] lit, input string tag);
      step(1'b1, a, b, tag);
      for (int i = 1; i < L; i++) step(1'b0, N'($urandom), N'($urandom), tag);
      check_m({tag, "_lit"}, bus.Multip, lit);
      check_v({tag, "_litvalid"}, bus.valid_out, 1'b1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      exp_m = '0;
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.Multiplicandos = '0;
      bus.Constantes = '0;
      @(posedge clk);
      do_reset(25'd7, 25'd9, "reset");

      directed(25'd3, 25'd5, 50'h000000000000F, "small");
      directed(25'h1FFFFFF, 25'd1, 50'h3FFFFFFFFFFFF, "neg_x_one");
      directed(25'h1FFFFFF, 25'h1FFFFFF, 50'h0000000000001, "neg_x_neg");
      directed(25'h0FFFFFF, 25'h0FFFFFF, 50'h0FFFFFE000001, "max_pos");
      directed(25'h1000000, 25'h1000000, 50'h1000000000000, "max_neg");

      // Hold: outputs frozen on the last product while en is low.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, N'($urandom), N'($urandom), "hold");
         check_m("hold_lit", bus.Multip, 50'h1000000000000);
      end

      // Mid-stream reset discards everything in flight.
      for (int i = 0; i < 4; i++) step(1'b1, N'($urandom), N'($urandom), "stream");
      do_reset(N'($urandom), N'($urandom), "midreset");
      for (int i = 0; i < 3; i++) begin
         step(1'b0, N'($urandom), N'($urandom), "post_reset");
         check_m("post_reset_zero", bus.Multip, '0);
      end

      for (int i = 0; i < 5000; i++) step(1'b1, N'($urandom), N'($urandom), "random");
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), N'($urandom), N'($urandom), "random_gap");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
